// File: rtl/lab2_debug_monitor_mem.sv
// Debug monitor memory stage: arbitrates one single-port monitor RAM between
// JTAG ocimem requests and CPU Avalon accesses, and keeps the debug status flags.
module lab2_debug_monitor_mem #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic [AW:0]   avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  input  logic [3:0]    avs_byteenable,
  output logic [31:0]   avs_readdata,
  output logic          avs_waitrequest,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error,
  output logic          resetlatch
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_J_RD  = 3'd1;
  localparam logic [2:0] S_J_CAP = 3'd2;
  localparam logic [2:0] S_J_WR  = 3'd3;
  localparam logic [2:0] S_C_RD  = 3'd4;
  localparam logic [2:0] S_C_CAP = 3'd5;
  localparam logic [2:0] S_C_WR  = 3'd6;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [AW-1:0] r_mon_a;
  logic [31:0]   r_mon_d;
  logic          r_pend;
  logic          r_pend_wr;
  logic          r_cpu_first;
  logic          r_ready;
  logic          r_error;
  logic          r_resetlatch;

  logic [31:0]   r_ram [0:(1<<AW)-1];
  logic [31:0]   r_ram_q;
  logic [AW-1:0] w_ram_addr;
  logic [31:0]   w_ram_wdata;
  logic [3:0]    w_ram_we;

  logic          w_jtag_strobe;
  logic          w_jtag_grant;
  logic          w_cpu_req;
  logic          w_ctrl_sel;
  logic          w_ctrl_wr;
  logic          w_j_done;
  logic [31:0]   w_ctrl_word;
  logic          w_unused;

  assign w_jtag_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_cpu_req     = avs_read | avs_write;
  assign w_ctrl_sel    = avs_address[AW];
  assign w_ctrl_wr     = (r_state == S_C_WR) && w_ctrl_sel && avs_write;
  assign w_j_done      = (r_state == S_J_CAP) || (r_state == S_J_WR);
  assign w_ctrl_word   = {29'b0, r_resetlatch, r_error, r_ready};
  assign w_unused      = ^{jdo[37:35], jdo[2:0]};

  // Arbitration. A strobe arriving this cycle holds off a fresh CPU grant so
  // the JTAG request it posts is not overtaken; the CPU is favoured only right
  // after a JTAG completion.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_cpu_first && w_cpu_req)
          w_state_nxt = avs_read ? S_C_RD : S_C_WR;
        else if (r_pend)
          w_state_nxt = r_pend_wr ? S_J_WR : S_J_RD;
        else if (w_jtag_strobe)
          w_state_nxt = S_IDLE;
        else if (avs_read)
          w_state_nxt = S_C_RD;
        else if (avs_write)
          w_state_nxt = S_C_WR;
      end
      S_J_RD:  w_state_nxt = S_J_CAP;
      S_J_CAP: w_state_nxt = S_IDLE;
      S_J_WR:  w_state_nxt = S_IDLE;
      S_C_RD:  w_state_nxt = S_C_CAP;
      S_C_CAP: w_state_nxt = S_IDLE;
      S_C_WR:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_jtag_grant = (r_state == S_IDLE) &&
                        ((w_state_nxt == S_J_RD) || (w_state_nxt == S_J_WR));

  // Single RAM port: JTAG uses MonAReg, CPU uses its own word address.
  always_comb begin
    w_ram_addr  = r_mon_a;
    w_ram_wdata = r_mon_d;
    w_ram_we    = 4'b0000;
    case (r_state)
      S_J_WR: w_ram_we = 4'b1111;
      S_C_RD, S_C_CAP: w_ram_addr = avs_address[AW-1:0];
      S_C_WR: begin
        w_ram_addr  = avs_address[AW-1:0];
        w_ram_wdata = avs_writedata;
        if (!w_ctrl_sel)
          w_ram_we = avs_byteenable;
      end
      default: ;
    endcase
  end

  // NOTE: the RAM array has no reset; clearing it would forbid block-RAM mapping.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (w_ram_we[i])
        r_ram[w_ram_addr][8*i +: 8] <= w_ram_wdata[8*i +: 8];
    r_ram_q <= r_ram[w_ram_addr];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_mon_a      <= '0;
      r_mon_d      <= '0;
      r_pend       <= 1'b0;
      r_pend_wr    <= 1'b0;
      r_cpu_first  <= 1'b0;
      r_ready      <= 1'b0;
      r_error      <= 1'b0;
      r_resetlatch <= 1'b1;
    end else begin
      r_state <= w_state_nxt;

      if (w_jtag_strobe) begin
        r_pend    <= 1'b1;
        r_pend_wr <= take_action_ocimem_b & ~take_action_ocimem_a & ~take_no_action_ocimem_a;
      end else if (w_jtag_grant) begin
        r_pend <= 1'b0;
      end

      if (w_j_done)
        r_cpu_first <= 1'b1;
      else if (r_state == S_IDLE)
        r_cpu_first <= 1'b0;

      if (take_action_ocimem_a)
        r_mon_a <= jdo[AW+25:26];
      else if (w_j_done)
        r_mon_a <= r_mon_a + 1'b1;

      if (take_action_ocimem_b)
        r_mon_d <= jdo[34:3];
      else if (r_state == S_J_CAP)
        r_mon_d <= r_ram_q;

      // A JTAG clear landing together with a CPU set leaves the flags cleared.
      if (take_action_ocimem_a && jdo[25]) begin
        r_ready <= 1'b0;
        r_error <= 1'b0;
      end else if (w_ctrl_wr) begin
        if (avs_writedata[0]) r_ready <= 1'b1;
        if (avs_writedata[1]) r_error <= 1'b1;
      end

      if (take_action_ocimem_a && jdo[24])
        r_resetlatch <= 1'b0;
    end
  end

  assign avs_readdata    = (r_state == S_C_CAP) ? (w_ctrl_sel ? w_ctrl_word : r_ram_q) : 32'h0;
  assign avs_waitrequest = w_cpu_req & ~((r_state == S_C_CAP) | (r_state == S_C_WR));
  assign MonDReg         = r_mon_d;
  assign monitor_ready   = r_ready;
  assign monitor_error   = r_error;
  assign resetlatch      = r_resetlatch;

endmodule
